// File: rtl/audio_bus_arbiter.sv
// Round-robin arbiter sharing one audio word bus among NUM_CH producers.
// Latches the chosen channel's word, holds it until accepted, then acks the requester.
module audio_bus_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    output logic [NUM_CH-1:0]            gnt,
    output logic                         bus_newin,
    output logic [DATA_WIDTH-1:0]        bus_dout,
    output logic [CH_W-1:0]              bus_ch,
    input  logic                         bus_rinc,
    output logic                         o_busy,
    output logic                         o_err,
    output logic [1:0]                   dbg_state
);

    // Bus handshake: bus_newin is a valid that stays high with bus_dout/bus_ch stable
    // until a cycle with bus_rinc=1 (ready); that cycle is the transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_W = (CH_W + 1)'(NUM_CH);

    state_t          state;
    logic [CH_W-1:0] ptr;
    logic [7:0]      watchdog;

    logic            pick_valid;
    logic [CH_W-1:0] pick_ch;
    logic [CH_W:0]   scan_idx;
    logic [CH_W-1:0] next_ptr;

    assign dbg_state = state;

    // First requester at or after ptr, wrapping modulo NUM_CH.
    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = {1'b0, ptr} + (CH_W + 1)'(i);
            if (scan_idx >= NUM_CH_W) begin
                scan_idx = scan_idx - NUM_CH_W;
            end
            if (!pick_valid && req[scan_idx[CH_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_ch    = scan_idx[CH_W-1:0];
            end
        end
    end

    assign next_ptr = (bus_ch == LAST_CH) ? '0 : bus_ch + CH_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            watchdog  <= '0;
            gnt       <= '0;
            bus_newin <= 1'b0;
            bus_dout  <= '0;
            bus_ch    <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus_dout  <= din[int'(pick_ch)*DATA_WIDTH +: DATA_WIDTH];
                        bus_ch    <= pick_ch;
                        bus_newin <= 1'b1;
                        watchdog  <= '0;
                        o_busy    <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (bus_rinc) begin
                        bus_newin <= 1'b0;
                        gnt       <= NUM_CH'(1) << bus_ch;
                        ptr       <= next_ptr;
                        state     <= DONE;
                    end else if (watchdog == WD_LAST) begin
                        // Abandon the word; the requester is skipped for this round.
                        bus_newin <= 1'b0;
                        o_err     <= 1'b1;
                        ptr       <= next_ptr;
                        state     <= DONE;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
